i2c_reg_poller: RTL and testbench

- Sequencer that drives the existing i2c_master command handshake (ena/addr/rw/data_wr/busy/data_rd/ack_error) to read a block of NUM_BYTES consecutive registers from one device, periodically or on demand.
- Write register pointer, then N reads, then stop; bytes land in a shadow buffer, which is committed atomically to a readable snapshot only on a clean transaction.
- Adds retry on ACK error, periodic polling and a pending-trigger latch.
- Sits between board top-level logic (LED/debug, sensor consumers) and i2c_master.

---
 rtl/i2c_reg_poller.sv | 133 +++++++++++++
 tb/tb_i2c_reg_poller.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_poller.sv
// i2c_reg_poller: drives i2c_master to write a register pointer then read a block, committing clean reads to a snapshot
module i2c_reg_poller #(
    parameter logic [6:0] DEVICE_ADDR = 7'h25,
    parameter logic [7:0] START_REG   = 8'h00,
    parameter int         NUM_BYTES   = 3,
    parameter int         POLL_PERIOD = 24000000,
    parameter int         MAX_RETRIES = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       trigger,
    output logic       i2c_ena,
    output logic [6:0] i2c_addr,
    output logic       i2c_rw,
    output logic [7:0] i2c_wdata,
    input  logic       i2c_busy,
    input  logic [7:0] i2c_rdata,
    input  logic       i2c_error,
    input  logic [3:0] rd_index,
    output logic [7:0] rd_data,
    output logic       snap_valid,
    output logic       done,
    output logic       fail,
    output logic       active,
    output logic [7:0] err_count
);
    typedef enum logic [1:0] {IDLE, START, XFER, WAIT_IDLE} state_t;

    state_t      state, state_next;
    logic        busy_last, rise, fall, pending, tick, abort;
    logic        go_start, err_fall, cap, settle, commit, go_retry, give_up;
    logic [31:0] timer;
    logic [4:0]  cmds, k;
    logic [3:0]  retry;
    logic [7:0]  shadow [16];
    logic [7:0]  snap [16];

    assign rise     = i2c_busy & ~busy_last;
    assign fall     = ~i2c_busy & busy_last;
    assign tick     = enable && POLL_PERIOD != 0 && timer == 32'(POLL_PERIOD - 1);
    assign go_start = state == IDLE && pending && !i2c_busy;
    assign err_fall = state == XFER && fall && i2c_error;
    assign cap      = state == XFER && fall && !i2c_error && cmds > 5'd1;
    assign settle   = state == WAIT_IDLE && !i2c_busy;
    assign commit   = settle && !abort;
    assign go_retry = settle && abort && int'(retry) < MAX_RETRIES;
    assign give_up  = settle && abort && !(int'(retry) < MAX_RETRIES);
    assign i2c_addr = DEVICE_ADDR;
    assign rd_data  = snap[rd_index];
    assign active   = state != IDLE;

    // next-state selection; datapath actions hang off the strobes above
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      state_next = go_start ? START : IDLE;
            START:     state_next = XFER;
            XFER:      state_next = (err_fall || (cap && k == 5'(NUM_BYTES - 1))) ? WAIT_IDLE : XFER;
            WAIT_IDLE: state_next = go_retry ? START : (settle ? IDLE : WAIT_IDLE);
            default:   state_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // busy edge history, poll timer and one-deep pending request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_last <= 1'b0;
            timer     <= '0;
            pending   <= 1'b0;
        end else begin
            busy_last <= i2c_busy;
            if (enable && POLL_PERIOD != 0) timer <= tick ? '0 : timer + 32'd1;
            pending   <= !go_start && (pending || trigger || tick);
        end
    end

    // command handshake, byte capture, atomic commit and failure accounting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            i2c_ena    <= 1'b0;
            i2c_rw     <= 1'b0;
            i2c_wdata  <= '0;
            cmds       <= '0;
            k          <= '0;
            retry      <= '0;
            abort      <= 1'b0;
            done       <= 1'b0;
            fail       <= 1'b0;
            snap_valid <= 1'b0;
            err_count  <= '0;
            shadow     <= '{default: 8'h00};
            snap       <= '{default: 8'h00};
        end else begin
            done <= commit;
            fail <= give_up;
            if (go_start) retry <= '0;
            if (go_retry) retry <= retry + 4'd1;
            if (state == START) begin
                i2c_ena   <= 1'b1;
                i2c_rw    <= 1'b0;
                i2c_wdata <= START_REG;
                cmds      <= '0;
                k         <= '0;
                abort     <= 1'b0;
            end
            if (state == XFER && rise) begin
                cmds <= cmds + 5'd1;
                if (cmds == 5'(NUM_BYTES)) i2c_ena <= 1'b0;
                else                       i2c_rw  <= 1'b1;
            end
            if (err_fall) begin
                i2c_ena <= 1'b0;
                abort   <= 1'b1;
            end
            if (cap) begin
                shadow[k[3:0]] <= i2c_rdata;
                k              <= k + 5'd1;
            end
            if (commit) begin
                snap       <= shadow;
                snap_valid <= 1'b1;
            end
            if (give_up && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_i2c_reg_poller.sv
// tb_i2c_reg_poller: directed checks of i2c_reg_poller against a behavioural i2c_master model
module tb_i2c_reg_poller;
    localparam int BYTE_CYC = 8;

    logic       clk = 1'b0;
    logic       reset_n, enable, trigger;
    logic       i2c_ena, i2c_rw, i2c_busy, i2c_error;
    logic [6:0] i2c_addr;
    logic [7:0] i2c_wdata, i2c_rdata;
    logic [3:0] rd_index;
    logic [7:0] rd_data, err_count;
    logic       snap_valid, done, fail, active;

    int checks = 0, failures = 0;
    int n_done = 0, n_fail = 0, n_wr = 0, n_rd = 0, nak_until = 0;
    logic [7:0] regs [4];
    logic [7:0] last_wdata = 8'hFF;
    logic       ena_after4 = 1'b1;

    int         ms, cnt, txn;
    logic       m_rw, first, nak;
    logic [1:0] ptr;

    always #5 clk = ~clk;

    i2c_reg_poller #(.NUM_BYTES(3), .POLL_PERIOD(1000), .MAX_RETRIES(3)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .trigger(trigger),
        .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_wdata(i2c_wdata),
        .i2c_busy(i2c_busy), .i2c_rdata(i2c_rdata), .i2c_error(i2c_error),
        .rd_index(rd_index), .rd_data(rd_data), .snap_valid(snap_valid),
        .done(done), .fail(fail), .active(active), .err_count(err_count)
    );

    // pulse counters
    always @(negedge clk) begin
        if (done) n_done <= n_done + 1;
        if (fail) n_fail <= n_fail + 1;
    end

    // behavioural i2c_master: accept a command on ena, stay busy for a byte, report data/ack on busy fall
    initial begin
        ms = 0; cnt = 0; txn = 0; m_rw = 1'b0; first = 1'b0; nak = 1'b0; ptr = 2'd0;
        i2c_busy = 1'b0; i2c_error = 1'b0; i2c_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                ms = 0; i2c_busy = 1'b0; i2c_error = 1'b0;
            end else if (ms == 0) begin
                if (i2c_ena) begin
                    m_rw = i2c_rw; i2c_busy = 1'b1; i2c_error = 1'b0; cnt = BYTE_CYC; ms = 1; first = 1'b1;
                    if (!m_rw) begin
                        n_wr++; last_wdata = i2c_wdata; ptr = i2c_wdata[1:0]; txn = 1; nak = n_wr <= nak_until;
                    end else begin
                        n_rd++; txn++;
                    end
                end
            end else if (ms == 1) begin
                if (first && txn == 4) ena_after4 = i2c_ena;
                first = 1'b0;
                if (cnt == 0) begin
                    i2c_busy = 1'b0; ms = 2;
                    if (m_rw) begin i2c_rdata = regs[ptr]; ptr++; end
                    else i2c_error = nak;
                end else cnt--;
            end else ms = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_trigger();
        @(negedge clk); trigger = 1'b1;
        @(negedge clk); trigger = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int base = n_done + n_fail;
        int t = 0;
        while (n_done + n_fail == base && t < 3000) begin @(negedge clk); t++; end
        check(tag, 32'(n_done + n_fail > base), 32'd1);
        repeat (5) @(negedge clk);
    endtask

    task automatic check_snap(input string tag, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        rd_index = 4'd0; #1 check({tag, "_b0"}, 32'(rd_data), 32'(a));
        rd_index = 4'd1; #1 check({tag, "_b1"}, 32'(rd_data), 32'(b));
        rd_index = 4'd2; #1 check({tag, "_b2"}, 32'(rd_data), 32'(c));
    endtask

    task automatic do_reset();
        @(negedge clk); reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int d0, f0, w0, r0, t;
        reset_n = 1'b0; enable = 1'b0; trigger = 1'b0; rd_index = 4'd0;
        regs[0] = 8'hA1; regs[1] = 8'hB2; regs[2] = 8'hC3; regs[3] = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_ena", 32'(i2c_ena), 32'd0);
        check("rst_addr", 32'(i2c_addr), 32'h25);
        check("rst_active", 32'(active), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_valid", 32'(snap_valid), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        check("rst_rdata", 32'(rd_data), 32'd0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // clean block read
        d0 = n_done; f0 = n_fail; w0 = n_wr; r0 = n_rd;
        pulse_trigger();
        wait_end("t1_end");
        check("t1_done", 32'(n_done - d0), 32'd1);
        check("t1_fail", 32'(n_fail - f0), 32'd0);
        check("t1_writes", 32'(n_wr - w0), 32'd1);
        check("t1_reads", 32'(n_rd - r0), 32'd3);
        check("t1_wdata", 32'(last_wdata), 32'h00);
        check("t1_ena_after4", 32'(ena_after4), 32'd0);
        check("t1_valid", 32'(snap_valid), 32'd1);
        check("t1_active", 32'(active), 32'd0);
        check_snap("t1", 8'hA1, 8'hB2, 8'hC3);
        rd_index = 4'd3; #1 check("t1_b3", 32'(rd_data), 32'd0);

        // NAK on the first attempt only: retry succeeds
        regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33;
        nak_until = n_wr + 1;
        d0 = n_done; f0 = n_fail; w0 = n_wr;
        pulse_trigger();
        wait_end("t3_end");
        check("t3_done", 32'(n_done - d0), 32'd1);
        check("t3_fail", 32'(n_fail - f0), 32'd0);
        check("t3_attempts", 32'(n_wr - w0), 32'd2);
        check("t3_errcnt", 32'(err_count), 32'd0);
        check_snap("t3", 8'h11, 8'h22, 8'h33);

        // NAK on every attempt: retries exhausted, snapshot untouched
        regs[0] = 8'h5A; regs[1] = 8'h5B; regs[2] = 8'h5C;
        nak_until = n_wr + 4;
        d0 = n_done; f0 = n_fail; w0 = n_wr; r0 = n_rd;
        pulse_trigger();
        wait_end("t2_end");
        repeat (200) @(negedge clk);
        check("t2_fail", 32'(n_fail - f0), 32'd1);
        check("t2_done", 32'(n_done - d0), 32'd0);
        check("t2_attempts", 32'(n_wr - w0), 32'd4);
        check("t2_reads", 32'(n_rd - r0), 32'd0);
        check("t2_errcnt", 32'(err_count), 32'd1);
        check("t2_valid", 32'(snap_valid), 32'd1);
        check_snap("t2", 8'h11, 8'h22, 8'h33);

        // two triggers while busy collapse into one follow-up
        regs[0] = 8'h44; regs[1] = 8'h55; regs[2] = 8'h66;
        d0 = n_done; w0 = n_wr;
        pulse_trigger();
        repeat (10) @(negedge clk);
        check("t5_active", 32'(active), 32'd1);
        pulse_trigger();
        repeat (10) @(negedge clk);
        pulse_trigger();
        wait_end("t5_first");
        wait_end("t5_second");
        repeat (300) @(negedge clk);
        check("t5_done", 32'(n_done - d0), 32'd2);
        check("t5_attempts", 32'(n_wr - w0), 32'd2);
        check_snap("t5", 8'h44, 8'h55, 8'h66);

        // reset in the middle of the read phase
        r0 = n_rd;
        pulse_trigger();
        t = 0;
        while (n_rd == r0 && t < 500) begin @(posedge clk); t++; end
        check("t6_reached_read", 32'(n_rd > r0), 32'd1);
        @(negedge clk); reset_n = 1'b0;
        #1;
        check("t6_ena", 32'(i2c_ena), 32'd0);
        check("t6_active", 32'(active), 32'd0);
        check("t6_valid", 32'(snap_valid), 32'd0);
        check("t6_errcnt", 32'(err_count), 32'd0);
        rd_index = 4'd1; #1 check("t6_rdata", 32'(rd_data), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        regs[0] = 8'h77; regs[1] = 8'h88; regs[2] = 8'h99;
        d0 = n_done;
        pulse_trigger();
        wait_end("t6_end");
        check("t6_done", 32'(n_done - d0), 32'd1);
        check("t6_valid_after", 32'(snap_valid), 32'd1);
        check_snap("t6", 8'h77, 8'h88, 8'h99);

        // periodic polling for 5000 enabled cycles, then frozen
        do_reset();
        d0 = n_done; w0 = n_wr;
        @(negedge clk); enable = 1'b1;
        repeat (5000) @(negedge clk);
        enable = 1'b0;
        repeat (3500) @(negedge clk);
        check("t4_done", 32'(n_done - d0), 32'd5);
        check("t4_attempts", 32'(n_wr - w0), 32'd5);
        check("t4_active", 32'(active), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
